// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART: parity modes, FSM state
// encodings, the RX FIFO entry layout and a ceil-log2 helper for sizing.
package uart_pkg;

  localparam int MAX_WORD = 9;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  typedef struct packed {
    logic                frame_err;
    logic                parity_err;
    logic [MAX_WORD-1:0] data;
  } rx_entry_t;

  // ceil(log2(n)), never below 1 so it can size a pointer or index directly
  function automatic int clog2_depth(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with an extra pointer MSB to tell
// full from empty. A push into a full FIFO succeeds only alongside a pop.
module uart_sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2_depth(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// Buffered UART: TX FIFO feeding a framed serialiser, and a mid-bit sampling
// deserialiser feeding an RX FIFO that carries per-word parity/frame flags.
module uart_fifo import uart_pkg::*; #(
  parameter int WORD_SIZE   = 8,
  parameter int PULSE_WIDTH = 4,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send_valid,
  input  logic [WORD_SIZE-1:0] data_bits_tx,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [WORD_SIZE-1:0] data_bits_rx,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  input  logic                 err_clr
);

  localparam parity_e PAR = (PARITY == 2) ? PAR_ODD :
                            (PARITY == 1) ? PAR_EVEN : PAR_NONE;
  localparam int CNT_W = clog2_depth(STOP_BITS * PULSE_WIDTH) + 1;
  localparam int IDX_W = clog2_depth(WORD_SIZE) + 1;
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(PULSE_WIDTH / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END  = CNT_W'(STOP_BITS * PULSE_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(WORD_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  // ---------------- TX path ----------------
  logic                 tx_push, tx_pop, tx_full, tx_empty, tx_load, tx_n;
  logic [WORD_SIZE-1:0] tx_head, tx_sh, tx_sh_n;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
  logic [IDX_W-1:0]     tx_idx, tx_idx_n;
  logic                 tx_par, tx_par_n;
  tx_state_e            tx_st, tx_st_n;

  assign tx_ready = !tx_full;
  assign tx_push  = send_valid && !tx_full;
  assign tx_pop   = tx_load;

  uart_sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(data_bits_tx),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
      tx     <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_idx <= tx_idx_n;
      tx_sh  <= tx_sh_n;
      tx_par <= tx_par_n;
      tx     <= tx_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt + 1'b1;
    tx_idx_n = tx_idx;
    tx_sh_n  = tx_sh;
    tx_par_n = tx_par;
    tx_load  = 1'b0;
    case (tx_st)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_load  = !tx_empty;
      end
      TX_START: if (tx_cnt == BIT_END) begin
        tx_st_n  = TX_DATA;
        tx_cnt_n = '0;
        tx_idx_n = '0;
      end
      TX_DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        tx_sh_n  = tx_sh >> 1;
        tx_idx_n = tx_idx + 1'b1;
        if (tx_idx == LAST_BIT) tx_st_n = (PAR == PAR_NONE) ? TX_STOP : TX_PARITY;
      end
      TX_PARITY: if (tx_cnt == BIT_END) begin
        tx_st_n  = TX_STOP;
        tx_cnt_n = '0;
      end
      TX_STOP: if (tx_cnt == STOP_END) begin
        tx_cnt_n = '0;
        tx_load  = !tx_empty;
        if (tx_empty) tx_st_n = TX_IDLE;
      end
      default: tx_st_n = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_st_n  = TX_START;
      tx_cnt_n = '0;
      tx_sh_n  = tx_head;
      tx_par_n = (^tx_head) ^ (PAR == PAR_ODD);
    end
    // tx is registered from the next state so a new bit appears on the same edge
    tx_n = 1'b1;
    case (tx_st_n)
      TX_START:  tx_n = 1'b0;
      TX_DATA:   tx_n = tx_sh_n[0];
      TX_PARITY: tx_n = tx_par_n;
      default:   tx_n = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  logic                 rx_s1, rx_s2;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [WORD_SIZE+1:0] rx_wdata, rx_head;
  logic [WORD_SIZE-1:0] rx_sh, rx_sh_n;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_n;
  logic [IDX_W-1:0]     rx_idx, rx_idx_n;
  logic                 rx_perr, rx_perr_n, rx_ferr, rx_ferr_n;
  rx_state_e            rx_st, rx_st_n;
  rx_entry_t            rx_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_sh   <= '0;
      rx_perr <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_st   <= rx_st_n;
      rx_cnt  <= rx_cnt_n;
      rx_idx  <= rx_idx_n;
      rx_sh   <= rx_sh_n;
      rx_perr <= rx_perr_n;
      rx_ferr <= rx_ferr_n;
    end
  end

  always_comb begin
    rx_st_n   = rx_st;
    rx_cnt_n  = rx_cnt + 1'b1;
    rx_idx_n  = rx_idx;
    rx_sh_n   = rx_sh;
    rx_perr_n = rx_perr;
    rx_ferr_n = rx_ferr;
    rx_push   = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_s2) begin
          rx_st_n   = RX_START;
          rx_perr_n = 1'b0;
          rx_ferr_n = 1'b0;
        end
      end
      RX_START: if (rx_cnt == HALF_END) begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        rx_st_n  = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s2, rx_sh[WORD_SIZE-1:1]};
        rx_idx_n = rx_idx + 1'b1;
        if (rx_idx == LAST_BIT) begin
          rx_idx_n = '0;
          rx_st_n  = (PAR == PAR_NONE) ? RX_STOP : RX_PARITY;
        end
      end
      RX_PARITY: if (rx_cnt == BIT_END) begin
        rx_cnt_n  = '0;
        rx_perr_n = rx_s2 ^ (^rx_sh) ^ (PAR == PAR_ODD);
        rx_st_n   = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_n  = '0;
        rx_idx_n  = rx_idx + 1'b1;
        rx_ferr_n = rx_ferr | !rx_s2;
        if (rx_idx == LAST_STOP) begin
          rx_push = 1'b1;
          rx_st_n = rx_ferr_n ? RX_BREAK : RX_IDLE;
        end
      end
      RX_BREAK: begin
        rx_cnt_n = '0;
        if (rx_s2) rx_st_n = RX_IDLE;
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  assign rx_entry = '{frame_err: rx_ferr_n, parity_err: rx_perr, data: MAX_WORD'(rx_sh)};
  assign rx_wdata = {rx_entry.frame_err, rx_entry.parity_err, WORD_SIZE'(rx_entry.data)};
  assign rx_pop   = rx_ready && !rx_empty;

  uart_sync_fifo #(.WIDTH(WORD_SIZE + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_wdata),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign rx_valid     = !rx_empty;
  assign data_bits_rx = rx_head[WORD_SIZE-1:0];
  assign parity_err   = rx_head[WORD_SIZE];
  assign frame_err    = rx_head[WORD_SIZE+1];

  // set beats clear when both land in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             overrun_err <= 1'b0;
    else if (rx_push && rx_full && !rx_pop) overrun_err <= 1'b1;
    else if (err_clr)                    overrun_err <= 1'b0;
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: loopback and raw-driven RX frames, with a
// scoreboard of expected RX entries popped as the DUT presents them.
module tb_uart_fifo;

  localparam int WS    = 8;
  localparam int PW    = 4;
  localparam int FRAME = (1 + WS + 1 + 1) * PW;

  logic          clk = 1'b0, rst = 1'b1;
  logic          send_valid = 1'b0, rx_ready = 1'b1, err_clr = 1'b0;
  logic          loop = 1'b1, rx_drv = 1'b1;
  logic [WS-1:0] data_bits_tx = '0, data_bits_rx;
  logic          tx_ready, tx, rx, rx_valid, parity_err, frame_err, overrun_err;

  int checks = 0, errors = 0;
  logic [WS+1:0] exp_q [$];

  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_fifo #(.WORD_SIZE(WS), .PULSE_WIDTH(PW), .PARITY(1), .STOP_BITS(1),
              .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .send_valid(send_valid), .data_bits_tx(data_bits_tx),
    .tx_ready(tx_ready), .tx(tx), .rx(rx), .rx_valid(rx_valid),
    .data_bits_rx(data_bits_rx), .rx_ready(rx_ready), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Scoreboard: every word the DUT hands over must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      chk("rx_expected_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("rx_word", 32'({frame_err, parity_err, data_bits_rx}), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_word(input logic [WS-1:0] w, input bit expect_rx);
    int n = 0;
    @(negedge clk);
    data_bits_tx = w;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(tx_ready), 32'd1);
    send_valid = 1'b1;
    @(posedge clk);
    #1 send_valid = 1'b0;
    if (expect_rx) exp_q.push_back({2'b00, w});
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    repeat (PW) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [WS-1:0] w, input logic par, input logic stop);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < WS; i++) drive_bit(w[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  initial begin
    logic [10:0] a5_bits;
    logic        spur;
    int          acc, fell_at;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_data_rx", 32'(data_bits_rx), 32'd0);
    chk("rst_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-frame: fill TX, interrupt during the all-zero data bits
    for (int i = 0; i < 5; i++) push_word(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    chk("pre_rst_tx_low", 32'(tx), 32'd0);
    chk("pre_rst_tx_full", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("midrst_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    spur = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (rx_valid || !tx) spur = 1'b1;
    end
    chk("no_spurious_after_rst", 32'(spur), 32'd0);

    // Frame format for 0xA5, even parity, looped back
    a5_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
    exp_q.push_back({2'b00, 8'hA5});
    @(negedge clk);
    data_bits_tx = 8'hA5;
    send_valid   = 1'b1;
    @(posedge clk);
    #1 send_valid = 1'b0;
    @(negedge clk);
    chk("a5_idle_before", 32'(tx), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk($sformatf("a5_bit%0d", i / PW), 32'(tx), 32'(a5_bits[i / PW]));
    end
    @(negedge clk);
    chk("a5_idle_after", 32'(tx), 32'd1);
    wait_drain(100);

    // Backpressure: six words on consecutive clocks, frames back to back
    acc = 0;
    fell_at = -1;
    for (int n = 0; n <= 2 + FRAME * 6; n++) begin
      @(negedge clk);
      if (n >= 2 && n < 2 + FRAME * 6 && ((n - 2) % FRAME) == 0)
        chk($sformatf("bp_start_%0d", (n - 2) / FRAME), 32'(tx), 32'd0);
      if (n > 2 && ((n - 2) % FRAME) == FRAME - 1)
        chk("bp_stop", 32'(tx), 32'd1);
      if (n == 2 + FRAME * 6) chk("bp_idle_end", 32'(tx), 32'd1);
      if (acc < 6) begin
        if (!tx_ready && fell_at < 0) begin
          fell_at = acc;
          chk("bp_ready_fall_after", 32'(acc), 32'd5);
        end
        data_bits_tx = 8'(acc + 1);
        send_valid   = tx_ready;
        if (tx_ready) begin
          exp_q.push_back({2'b00, 8'(acc + 1)});
          acc++;
        end
      end else begin
        send_valid = 1'b0;
      end
    end
    chk("bp_all_accepted", 32'(acc), 32'd6);
    wait_drain(200);

    // Parity error then a clean frame, driven raw
    loop = 1'b0;
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back({2'b01, 8'h3C});
    send_raw(8'h3C, 1'b1, 1'b1);
    exp_q.push_back({2'b00, 8'h3C});
    send_raw(8'h3C, 1'b0, 1'b1);
    drive_bit(1'b1);
    wait_drain(100);

    // Frame error, three bit-times of break, then a clean 0x55
    exp_q.push_back({2'b10, 8'h81});
    send_raw(8'h81, 1'b0, 1'b0);
    repeat (3) drive_bit(1'b0);
    repeat (2) drive_bit(1'b1);
    chk("break_no_extra", 32'(exp_q.size()), 32'd0);
    exp_q.push_back({2'b00, 8'h55});
    send_raw(8'h55, 1'b0, 1'b1);
    drive_bit(1'b1);
    wait_drain(100);

    // Overrun: five looped frames into a four-entry RX FIFO nobody drains
    loop = 1'b1;
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'(8'h10 + i), i < 4);
    repeat (6 * FRAME) @(negedge clk);
    chk("ovr_flag", 32'(overrun_err), 32'd1);
    chk("ovr_rx_valid", 32'(rx_valid), 32'd1);
    chk("ovr_head", 32'(data_bits_rx), 32'h10);
    rx_ready = 1'b1;
    wait_drain(50);
    repeat (8) @(negedge clk);
    chk("ovr_fifo_empty", 32'(rx_valid), 32'd0);
    chk("ovr_sticky", 32'(overrun_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", 32'(overrun_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
